queue: RTL and testbench



---
 rtl/queue.sv | 69 ++++++
 tb/tb_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/queue.sv
// rtl/queue.sv - synchronous single-clock FIFO with registered read data
module queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             read,
  input  logic             write,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_read;
  logic             do_write;

  // Accept decisions; a write while full is still taken when a pop frees the slot
  always_comb begin
    do_read  = read && !empty;
    do_write = write && (!full || read);
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Status flags follow the occupancy register directly
  always_comb begin
    empty = (count == '0);
    full  = (count == FULL_COUNT);
  end

endmodule

// File: tb/tb_queue.sv
// tb/tb_queue.sv - directed self-checking bench for queue
module tb_queue;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        read;
  logic        write;
  logic [15:0] dout;
  logic        empty;
  logic        full;

  int passed;
  int total;
  int model[$];
  int exp_word;
  int next_word;

  queue #(.WIDTH(16), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .read  (read),
    .write (write),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    write = 1'b1;
    read  = 1'b0;
    din   = v;
    tick();
    write = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] v);
    read  = 1'b1;
    write = 1'b0;
    tick();
    read  = 1'b0;
    check(tag, dout, v);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    din    = '0;
    read   = 1'b0;
    write  = 1'b0;
    reset  = 1'b0;

    // reset state before any clock edge
    #2;
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_dout", dout, 0);

    tick();
    reset = 1'b1;

    // order check
    push(16'd100);
    check("first_write_empty", empty, 0);
    push(16'd10);
    push(16'd250);
    push(16'd40);
    pop_check("order_0", 16'd100);
    pop_check("order_1", 16'd10);
    pop_check("order_2", 16'd250);
    pop_check("order_3", 16'd40);
    check("order_empty", empty, 1);

    // fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
    end
    check("fill_full", full, 1);
    push(16'd99);
    check("overflow_full", full, 1);
    for (int i = 1; i <= 8; i++) begin
      pop_check("drain", 16'(i));
    end
    check("drain_empty", empty, 1);

    // underflow: dout holds 8
    read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("underflow_dout", dout, 8);
      check("underflow_empty", empty, 1);
    end
    read = 1'b0;
    push(16'd7);
    pop_check("after_underflow", 16'd7);

    // simultaneous with 3 entries
    push(16'd5);
    push(16'd6);
    push(16'd7);
    read = 1'b1; write = 1'b1; din = 16'd8;
    tick();
    read = 1'b0; write = 1'b0;
    check("simul_mid_dout", dout, 5);
    check("simul_mid_empty", empty, 0);
    check("simul_mid_full", full, 0);
    pop_check("simul_mid_1", 16'd6);
    pop_check("simul_mid_2", 16'd7);
    pop_check("simul_mid_3", 16'd8);
    check("simul_mid_drained", empty, 1);

    // simultaneous while full
    for (int i = 11; i <= 18; i++) begin
      push(16'(i));
    end
    check("simul_full_pre", full, 1);
    read = 1'b1; write = 1'b1; din = 16'd19;
    tick();
    read = 1'b0; write = 1'b0;
    check("simul_full_flag", full, 1);
    check("simul_full_dout", dout, 11);
    for (int i = 12; i <= 19; i++) begin
      pop_check("simul_full_drain", 16'(i));
    end
    check("simul_full_empty", empty, 1);

    // simultaneous while empty: no fall-through
    read = 1'b1; write = 1'b1; din = 16'd9;
    tick();
    read = 1'b0; write = 1'b0;
    check("simul_empty_dout", dout, 19);
    check("simul_empty_flag", empty, 0);
    pop_check("simul_empty_pop", 16'd9);

    // wrap: bursts of 4 pushes and 3 pops, then drain
    next_word = 200;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        push(16'(next_word));
        model.push_back(next_word);
        next_word = next_word + 1;
      end
      if (r == 4) check("wrap_peak_full", full, 1);
      for (int k = 0; k < 3; k++) begin
        exp_word = model.pop_front();
        pop_check("wrap_burst", 16'(exp_word));
      end
    end
    while (model.size() > 0) begin
      exp_word = model.pop_front();
      pop_check("wrap_drain", 16'(exp_word));
    end
    check("wrap_empty", empty, 1);

    // mid-operation reset with 4 entries held
    push(16'd31);
    push(16'd32);
    push(16'd33);
    push(16'd34);
    pop_check("pre_reset_pop", 16'd31);
    push(16'd35);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_empty", empty, 1);
    check("midreset_full", full, 0);
    check("midreset_dout", dout, 0);
    tick();
    reset = 1'b1;
    push(16'd77);
    pop_check("post_reset_pop", 16'd77);
    check("post_reset_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
